// File: rtl/lbr_dump_ctrl_pkg.sv
// Shared LBR command encodings, dump FSM state codes and index-width helper.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package lbr_dump_ctrl_pkg;

  // LBR command encodings seen on core_lbrReq / lbr_lbrReq
  localparam logic [1:0] LBR_NONE  = 2'b00;
  localparam logic [1:0] LBR_READ  = 2'b10;
  localparam logic [1:0] LBR_CLEAR = 2'b11;

  // Dump FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FREEZE = 3'd1;
  localparam state_t ST_ISSUE  = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;
  localparam state_t ST_CLEAR  = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  // Width of a word index covering 2*depth words (source + target per entry)
  function automatic int idx_width(input int depth);
    return $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/lbr_dump_seq_counter.sv
// Word counter for the LBR dump: load-zero, saturating increment, last-word flag.
// Latency: count updates one cycle after load_zero/incr.
// Backpressure: none; the controller only increments after a word is accepted.
module lbr_dump_seq_counter import lbr_dump_ctrl_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_zero,
  input  logic          incr,
  output logic [IW-1:0] count,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * DEPTH - 1);

  logic [IW-1:0] count_q;
  logic [IW-1:0] count_d;

  assign count = count_q;
  assign last  = (count_q == LAST_IDX);

  // Next count: restart on load, otherwise step forward but never past the last word
  always_comb begin
    count_d = count_q;
    if (load_zero) begin
      count_d = '0;
    end else if (incr && !last) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lbr_dump_ctrl.sv
// Freezes the LBR and streams all 2*DEPTH words out, optionally clearing it afterwards.
// Latency: one word per 3 cycles (issue, wait, hold); dump_done 1+6*DEPTH(+1 if clear)+1 cycles after dump_start.
// Backpressure: out_ready low holds the HOLD state with data stable; core requests get core_wait while busy.
module lbr_dump_ctrl import lbr_dump_ctrl_pkg::*; #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 8,
  localparam int IW         = idx_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            core_lbrReq,
  input  logic [DATA_WIDTH-1:0] core_RW_address,
  output logic                  core_wait,
  input  logic                  dump_start,
  input  logic                  dump_clear,
  input  logic                  dump_abort,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]         out_index,
  output logic                  lbr_stall,
  output logic [1:0]            lbr_lbrReq,
  output logic [DATA_WIDTH-1:0] lbr_RW_address,
  input  logic [DATA_WIDTH-1:0] lbr_output_data
);

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  clear_q, clear_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]         out_index_q, out_index_d;

  logic          cnt_load;
  logic          cnt_incr;
  logic [IW-1:0] cnt;
  logic          cnt_last;
  logic          busy;

  lbr_dump_seq_counter #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .load_zero (cnt_load),
    .incr      (cnt_incr),
    .count     (cnt),
    .last      (cnt_last)
  );

  // Dump sequencing: a start that collides with a core command is parked for one cycle
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    clear_d     = clear_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    cnt_load    = 1'b0;
    cnt_incr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          cnt_load  = 1'b1;
          state_d   = ST_FREEZE;
        end else if (dump_start) begin
          clear_d = dump_clear;
          if (core_lbrReq != LBR_NONE) begin
            pending_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_FREEZE;
          end
        end
      end
      ST_FREEZE: state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT: begin
        out_data_d  = lbr_output_data;
        out_index_d = cnt;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (cnt_last) begin
            state_d = clear_q ? ST_CLEAR : ST_DONE;
          end else begin
            cnt_incr = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort wins over a handshake in the same cycle: the presented word is dropped
    if (dump_abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d  = ST_DONE;
      cnt_incr = 1'b0;
    end
  end

  // Output decode and LBR command mux; the core owns the LBR only while idle
  always_comb begin
    busy           = (state_q != ST_IDLE);
    dump_busy      = busy;
    lbr_stall      = busy;
    dump_done      = (state_q == ST_DONE);
    out_valid      = (state_q == ST_HOLD);
    out_data       = out_data_q;
    out_index      = out_index_q;
    core_wait      = busy && (core_lbrReq != LBR_NONE);
    lbr_lbrReq     = LBR_NONE;
    lbr_RW_address = '0;
    case (state_q)
      ST_IDLE: begin
        if (!reset) begin
          lbr_lbrReq     = core_lbrReq;
          lbr_RW_address = core_RW_address;
        end
      end
      ST_ISSUE: begin
        lbr_lbrReq     = LBR_READ;
        lbr_RW_address = DATA_WIDTH'(cnt);
      end
      ST_CLEAR: lbr_lbrReq = LBR_CLEAR;
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      clear_q     <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      clear_q     <= clear_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

endmodule

// File: tb/tb_lbr_dump_ctrl.sv
// Scoreboard bench for lbr_dump_ctrl with a behavioural LBR model.
// Latency: expected words queued at dump start, popped by the monitor on each accepted word.
// Backpressure: bench drives out_ready, including a multi-cycle stall.
module tb_lbr_dump_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int NW    = 2 * DEPTH;
  localparam int IW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    core_lbrReq;
  logic [DW-1:0] core_RW_address;
  logic          core_wait;
  logic          dump_start, dump_clear, dump_abort;
  logic          dump_busy, dump_done;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          lbr_stall;
  logic [1:0]    lbr_lbrReq;
  logic [DW-1:0] lbr_RW_address;
  logic [DW-1:0] lbr_output_data;

  lbr_dump_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .core_lbrReq     (core_lbrReq),
    .core_RW_address (core_RW_address),
    .core_wait       (core_wait),
    .dump_start      (dump_start),
    .dump_clear      (dump_clear),
    .dump_abort      (dump_abort),
    .dump_busy       (dump_busy),
    .dump_done       (dump_done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_index       (out_index),
    .lbr_stall       (lbr_stall),
    .lbr_lbrReq      (lbr_lbrReq),
    .lbr_RW_address  (lbr_RW_address),
    .lbr_output_data (lbr_output_data)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(32'h0000_A05C + i * 32'h0000_0137);
  endfunction

  // LBR model: read data one cycle after a read command, clear wipes all entries
  logic [DW-1:0] mem [NW];
  logic          mem_restore;
  always @(posedge clock) begin
    if (mem_restore) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_val(i);
    end else if (lbr_lbrReq == 2'b11) begin
      for (int i = 0; i < NW; i++) mem[i] <= '0;
    end
    if (lbr_lbrReq == 2'b10) lbr_output_data <= mem[lbr_RW_address[IW-1:0]];
  end

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] dat;
  } word_t;

  word_t sb[$];
  word_t mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    done_cnt = 0;
  int    clear_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word, tracks done pulses and clears
  always @(negedge clock) begin
    if (!reset) begin
      if (dump_done) done_cnt++;
      if (lbr_lbrReq == 2'b11) begin
        clear_cnt++;
        check("clear_after_last_word", sb.size(), 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word", out_index, out_data);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("word%0d", mon_e.idx), {out_index, out_data}, {mon_e.idx, mon_e.dat});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_words(input int first, input int last, input bit zero);
    word_t w;
    for (int i = first; i <= last; i++) begin
      w.idx = IW'(i);
      w.dat = zero ? '0 : init_val(i);
      sb.push_back(w);
    end
  endtask

  // Full dump from the current cycle; optional 5-cycle out_ready stall on one word
  task automatic run_dump(input bit clr, input int stall_idx, input int exp_len, input string name);
    int n;
    bit stalled;
    n = 0;
    stalled = 0;
    dump_start = 1'b1;
    dump_clear = clr;
    while (n < 300) begin
      tick();
      n++;
      dump_start = 1'b0;
      dump_clear = 1'b0;
      if (dump_done) break;
      if (out_valid && int'(out_index) == stall_idx && !stalled) begin
        stalled = 1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          n++;
          check({name, "_hold_valid"}, out_valid, 1);
          check({name, "_hold_index"}, out_index, stall_idx);
          check({name, "_hold_data"}, out_data, init_val(stall_idx));
          check({name, "_hold_stall"}, lbr_stall, 1);
        end
        out_ready = 1'b1;
      end
    end
    check({name, "_done_cycle"}, n, exp_len);
    tick();
    check({name, "_done_one_cycle"}, dump_done, 0);
    check({name, "_stall_released"}, lbr_stall, 0);
    check({name, "_all_words"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n;
  int c0;

  initial begin
    reset = 1'b1;
    mem_restore = 1'b1;
    core_lbrReq = 2'b00;
    core_RW_address = '0;
    dump_start = 1'b0;
    dump_clear = 1'b0;
    dump_abort = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    mem_restore = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_lbr_stall", lbr_stall, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_lbr_req", lbr_lbrReq, 0);
    tick();

    // Plain dump, out_ready held high
    push_words(0, NW - 1, 0);
    run_dump(0, -1, 50, "plain");

    // Stall on word 3
    push_words(0, NW - 1, 0);
    run_dump(0, 3, 55, "stall");

    // Dump with clear, then a dump that must read zeros
    push_words(0, NW - 1, 0);
    run_dump(1, -1, 51, "clr");
    check("clear_once", clear_cnt, 1);
    push_words(0, NW - 1, 1);
    run_dump(0, -1, 50, "after_clr");
    mem_restore = 1'b1;
    tick();
    mem_restore = 1'b0;

    // Core read colliding with dump_start, then a core read mid-dump
    push_words(0, NW - 1, 0);
    core_lbrReq = 2'b10;
    core_RW_address = 16'd5;
    dump_start = 1'b1;
    #2;
    check("core_fwd_cmd", lbr_lbrReq, 2);
    check("core_fwd_addr", lbr_RW_address, 5);
    check("core_wait_idle", core_wait, 0);
    tick();
    dump_start = 1'b0;
    core_lbrReq = 2'b00;
    core_RW_address = '0;
    n = 0;
    while (!dump_busy && n < 10) begin
      tick();
      n++;
    end
    check("pending_dump_started", dump_busy, 1);
    core_lbrReq = 2'b10;
    core_RW_address = 16'd7;
    #2;
    check("core_wait_busy", core_wait, 1);
    check("freeze_no_cmd", lbr_lbrReq, 0);
    tick();
    check("issue_cmd", lbr_lbrReq, 2);
    check("issue_addr", lbr_RW_address, 0);
    check("core_wait_issue", core_wait, 1);
    core_lbrReq = 2'b00;
    core_RW_address = '0;
    n = 0;
    while (!dump_done && n < 100) begin
      tick();
      n++;
    end
    check("pending_dump_done", dump_done, 1);
    tick();
    check("pending_all_words", sb.size(), 0);

    // Abort while word 5 is presented
    push_words(0, 4, 0);
    dump_start = 1'b1;
    dump_clear = 1'b1;
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      dump_start = 1'b0;
      dump_clear = 1'b0;
      if (out_valid && out_index == 4'd5) break;
    end
    check("abort_word5_cycle", n, 19);
    c0 = clear_cnt;
    out_ready = 1'b0;
    dump_abort = 1'b1;
    tick();
    dump_abort = 1'b0;
    check("abort_valid_dropped", out_valid, 0);
    check("abort_done_pulse", dump_done, 1);
    check("abort_stall_in_done", lbr_stall, 1);
    tick();
    check("abort_stall_released", lbr_stall, 0);
    check("abort_idle", dump_busy, 0);
    check("abort_no_clear", clear_cnt, c0);
    check("abort_words", sb.size(), 0);
    out_ready = 1'b1;
    tick();

    // Reset during WAIT of word 2
    push_words(0, 1, 0);
    dump_start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      dump_start = 1'b0;
    end
    check("rstw_busy", dump_busy, 1);
    check("rstw_in_wait", out_valid, 0);
    check("rstw_prev_index", out_index, 1);
    c0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("rstw_out_valid", out_valid, 0);
    check("rstw_out_data", out_data, 0);
    check("rstw_out_index", out_index, 0);
    check("rstw_dump_done", dump_done, 0);
    check("rstw_lbr_stall", lbr_stall, 0);
    check("rstw_busy_after", dump_busy, 0);
    check("rstw_lbr_req", lbr_lbrReq, 0);
    repeat (3) tick();
    check("rstw_no_done", done_cnt, c0);
    check("rstw_words", sb.size(), 0);

    check("done_count", done_cnt, 6);
    check("clear_count", clear_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lbr_dump_ctrl.md
LBR_DUMP_CTRL -- requirements
Module: lbr_dump_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: LBR data and address width.
REQ-002 Parameter DEPTH, default 8: LBR branch entries; 2*DEPTH words (source, target) are readable.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 core_lbrReq  in  2  core-side LBR command; 00 none, 10 read, 11 clear.
REQ-006 core_RW_address  in  DATA_WIDTH  core-side LBR word address.
REQ-007 core_wait  out  1  core request not forwarded this cycle; core holds its request.
REQ-008 dump_start  in  1  one-cycle pulse requesting a full LBR dump.
REQ-009 dump_clear  in  1  sampled with dump_start; 1 = clear the LBR after the last word.
REQ-010 dump_abort  in  1  terminate an active dump.
REQ-011 dump_busy  out  1  dump in progress (any state except IDLE).
REQ-012 dump_done  out  1  one-cycle pulse on dump completion or abort.
REQ-013 out_valid / out_ready  out / in  1 / 1  valid-ready stream of dumped words.
REQ-014 out_data  out  DATA_WIDTH  dumped word.
REQ-015 out_index  out  clog2(2*DEPTH)  word index of out_data.
REQ-016 lbr_stall  out  1  freezes LBR recording; drives the LBR stall input.
REQ-017 lbr_lbrReq / lbr_RW_address  out  2 / DATA_WIDTH  command and address to the LBR.
REQ-018 lbr_output_data  in  DATA_WIDTH  LBR read data, valid one cycle after a read command.

Function
REQ-019 States: IDLE, FREEZE, ISSUE, WAIT, HOLD, CLEAR, DONE.
REQ-020 IDLE: core_lbrReq/core_RW_address pass straight to lbr_lbrReq/lbr_RW_address; core_wait=0; lbr_stall=0.
REQ-021 IDLE with dump_start and core_lbrReq!=00 in the same cycle: core command forwarded; dump is latched pending and starts the next cycle.
REQ-022 IDLE, dump_start (or pending): go to FREEZE; latch dump_clear; word counter := 0.
REQ-023 FREEZE: lbr_stall=1, lbr_lbrReq=00; one cycle, then ISSUE.
REQ-024 ISSUE: lbr_lbrReq=10, lbr_RW_address=counter (zero-extended); next WAIT.
REQ-025 WAIT: capture lbr_output_data into out_data, out_index=counter; next HOLD.
REQ-026 HOLD: out_valid=1; out_data/out_index stable until out_ready; on out_valid&out_ready: if counter==2*DEPTH-1 go to CLEAR (clear latched) or DONE, else counter+1 and go to ISSUE.
REQ-027 Counter never wraps within a dump; the last word has index 2*DEPTH-1.
REQ-028 CLEAR: lbr_lbrReq=11 for exactly one cycle; next DONE.
REQ-029 DONE: dump_done=1 for one cycle, lbr_stall released; next IDLE.
REQ-030 FREEZE through DONE: lbr_stall=1 (DONE included), core_wait=1 whenever core_lbrReq!=00, core command not forwarded.
REQ-031 dump_abort in any non-IDLE state except DONE: next state DONE; out_valid dropped next cycle; no CLEAR issued; the word being presented is discarded.
REQ-032 dump_start while busy: ignored.
REQ-033 Throughput: at most one word per 3 cycles (ISSUE, WAIT, HOLD); full dump with out_ready held 1 takes 1+3*2*DEPTH+(clear?1:0)+1 cycles from dump_start.

Reset
REQ-034 On reset: state IDLE, pending and clear latches 0, counter 0, out_valid 0, out_data 0, out_index 0, dump_done 0, lbr_stall 0, lbr_lbrReq 00.
REQ-035 Reset mid-dump: abandon without dump_done, CLEAR or output; LBR is released the next cycle.

Structure
REQ-036 Shared package: LBR command encodings (NONE=00, READ=10, CLEAR=11), FSM state enum, index-width function.
REQ-037 One sub-module, lbr_dump_seq_counter: word counter with load-zero, increment and last flag.

Verification
REQ-038 Reset, then dump_start with out_ready=1 and DEPTH=8 -> 16 words, out_index 0..15, out_data matching LBR contents, dump_done exactly 50 cycles after dump_start.
REQ-039 out_ready low 5 cycles on word 3 -> out_data/out_index held, no word lost or duplicated, lbr_stall stays 1.
REQ-040 dump_start with dump_clear=1 -> single lbr_lbrReq=11 after word 15, before dump_done; a subsequent dump reads cleared entries.
REQ-041 core_lbrReq=10 in the same cycle as dump_start -> core read forwarded, dump begins next cycle; core_lbrReq=10 mid-dump -> core_wait=1, not forwarded.
REQ-042 dump_abort during word 5 HOLD -> out_valid low next cycle, dump_done pulse, no CLEAR, lbr_stall 0 after DONE.
REQ-043 reset asserted during WAIT -> all outputs at reset values next cycle; no dump_done pulse.
